// File: rtl/md5_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md5_dispatch_pkg
// Purpose  : Shared sizes and FSM state encodings for the md5 dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package md5_dispatch_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int DIGEST_WORDS    = 4;
    localparam int UNIT_AW         = 5;
    localparam int BLK_WAW         = 4;
    localparam int DIG_WAW         = 2;
    localparam int MAX_UNITS       = 32;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_START = 2'd2
    } load_state_t;

    typedef enum logic [2:0] {
        DR_SCAN = 3'd0,
        DR_ADDR = 3'd1,
        DR_DATA = 3'd2,
        DR_HOLD = 3'd3,
        DR_CLR  = 3'd4
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/md5_dispatch_prienc.sv
`default_nettype none
// ============================================================================
// Module   : md5_dispatch_prienc
// Purpose  : Lowest-set-bit priority encoder returning an index and found flag.
// Revision : 1.0 - initial release
// ============================================================================
module md5_dispatch_prienc
    import md5_dispatch_pkg::*;
#(
    parameter int WIDTH = MAX_UNITS,
    parameter int IDX_W = UNIT_AW
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan high to low so the lowest set bit wins the final assignment.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/md5_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : md5_dispatcher
// Purpose  : Streams 512-bit blocks into free md5 units and drains digests,
//            tagged with their job ID. MD5_DISPATCH_CYCLES_EN appends a
//            per-unit busy-cycle count as a fifth digest word.
// Revision : 1.0 - initial release
// ============================================================================
module md5_dispatcher
    import md5_dispatch_pkg::*;
#(
    parameter int NUM_UNITS = 32,
    parameter int ID_W      = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [ID_W-1:0] out_id,
    output logic            out_last,
    output logic            md5_write,
    output logic [31:0]     md5_writedata,
    output logic [8:0]      md5_writeaddr,
    output logic [6:0]      md5_readaddr,
    input  logic [31:0]     md5_readdata,
    output logic [31:0]     md5_start,
    output logic [31:0]     md5_reset,
    input  logic [31:0]     md5_done
);

    localparam logic [31:0] C_UNIT_MASK = (NUM_UNITS >= 32) ? 32'hFFFF_FFFF
                                        : 32'((64'd1 << NUM_UNITS) - 64'd1);
`ifdef MD5_DISPATCH_CYCLES_EN
    localparam logic [2:0]  C_LAST_RC   = 3'(DIGEST_WORDS);
`else
    localparam logic [2:0]  C_LAST_RC   = 3'(DIGEST_WORDS - 1);
`endif

    logic [31:0]        r_busy;
    logic [ID_W-1:0]    r_tag [MAX_UNITS];

    load_state_t        r_ld_state;
    logic [UNIT_AW-1:0] r_lu;
    logic [BLK_WAW-1:0] r_wc;
    logic               r_in_ready;
    logic               r_md5_write;
    logic [31:0]        r_md5_writedata;
    logic [8:0]         r_md5_writeaddr;
    logic [31:0]        r_md5_start;

    drain_state_t       r_dr_state;
    logic [UNIT_AW-1:0] r_du;
    logic [2:0]         r_rc;
    logic [6:0]         r_md5_readaddr;
    logic [31:0]        r_md5_reset;
    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic [ID_W-1:0]    r_out_id;
    logic               r_out_last;

    logic [UNIT_AW-1:0] w_free_idx;
    logic               w_free_found;
    logic [UNIT_AW-1:0] w_done_idx;
    logic               w_done_found;
    logic               w_in_fire;
    logic [2:0]         w_rc_next;
    logic [31:0]        w_word;

    assign w_in_fire = in_valid & r_in_ready;
    assign w_rc_next = r_rc + 3'd1;

    md5_dispatch_prienc #(.WIDTH(MAX_UNITS), .IDX_W(UNIT_AW)) u_free_enc (
        .i_req   (~r_busy & C_UNIT_MASK),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    // A unit whose start pulse is still on the bus has not really begun yet.
    md5_dispatch_prienc #(.WIDTH(MAX_UNITS), .IDX_W(UNIT_AW)) u_done_enc (
        .i_req   (r_busy & md5_done & ~r_md5_start & C_UNIT_MASK),
        .o_idx   (w_done_idx),
        .o_found (w_done_found)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ld_state      <= LD_IDLE;
            r_lu            <= '0;
            r_wc            <= '0;
            r_in_ready      <= 1'b0;
            r_md5_write     <= 1'b0;
            r_md5_writedata <= '0;
            r_md5_writeaddr <= '0;
            r_md5_start     <= '0;
        end else begin
            r_md5_write <= 1'b0;
            r_md5_start <= '0;
            case (r_ld_state)
                LD_IDLE: begin
                    if (w_free_found) begin
                        r_lu       <= w_free_idx;
                        r_wc       <= '0;
                        r_in_ready <= 1'b1;
                        r_ld_state <= LD_LOAD;
                    end
                end
                LD_LOAD: begin
                    if (w_in_fire) begin
                        r_md5_write     <= 1'b1;
                        r_md5_writedata <= in_data;
                        r_md5_writeaddr <= {r_lu, r_wc};
                        r_wc            <= r_wc + BLK_WAW'(1);
                        if (r_wc == BLK_WAW'(WORDS_PER_BLOCK - 1)) begin
                            r_in_ready <= 1'b0;
                            r_ld_state <= LD_START;
                        end
                    end
                end
                LD_START: begin
                    r_md5_start <= 32'd1 << r_lu;
                    r_ld_state  <= LD_IDLE;
                end
                default: r_ld_state <= LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && r_ld_state == LD_LOAD && w_in_fire && r_wc == '0) begin
            r_tag[r_lu] <= in_id;
        end
    end

    // Load and drain never share a unit, so set and clear cannot collide.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            if (r_ld_state == LD_START) r_busy[r_lu] <= 1'b1;
            if (r_dr_state == DR_CLR)   r_busy[r_du] <= 1'b0;
        end
    end

`ifdef MD5_DISPATCH_CYCLES_EN
    logic [31:0] r_cyc [MAX_UNITS];

    for (genvar u = 0; u < MAX_UNITS; u++) begin : g_cyc
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_cyc[u] <= '0;
            end else if (r_ld_state == LD_START && r_lu == UNIT_AW'(u)) begin
                r_cyc[u] <= '0;
            end else if (r_busy[u] && !md5_done[u]) begin
                r_cyc[u] <= r_cyc[u] + 32'd1;
            end
        end
    end

    assign w_word = (r_rc == 3'(DIGEST_WORDS)) ? r_cyc[r_du] : md5_readdata;
`else
    assign w_word = md5_readdata;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dr_state     <= DR_SCAN;
            r_du           <= '0;
            r_rc           <= '0;
            r_md5_readaddr <= '0;
            r_md5_reset    <= '1;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_id       <= '0;
            r_out_last     <= 1'b0;
        end else begin
            r_md5_reset <= '0;
            case (r_dr_state)
                DR_SCAN: begin
                    if (w_done_found) begin
                        r_du           <= w_done_idx;
                        r_rc           <= '0;
                        r_md5_readaddr <= {w_done_idx, DIG_WAW'(0)};
                        r_dr_state     <= DR_ADDR;
                    end
                end
                DR_ADDR: r_dr_state <= DR_DATA;
                DR_DATA: begin
                    r_out_data  <= w_word;
                    r_out_id    <= r_tag[r_du];
                    r_out_last  <= (r_rc == C_LAST_RC);
                    r_out_valid <= 1'b1;
                    r_dr_state  <= DR_HOLD;
                end
                DR_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_md5_reset <= 32'd1 << r_du;
                            r_dr_state  <= DR_CLR;
                        end else begin
                            r_rc           <= w_rc_next;
                            r_md5_readaddr <= {r_du, w_rc_next[DIG_WAW-1:0]};
                            r_dr_state     <= DR_ADDR;
                        end
                    end
                end
                DR_CLR:  r_dr_state <= DR_SCAN;
                default: r_dr_state <= DR_SCAN;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign md5_write     = r_md5_write;
    assign md5_writedata = r_md5_writedata;
    assign md5_writeaddr = r_md5_writeaddr;
    assign md5_start     = r_md5_start;
    assign md5_reset     = r_md5_reset;
    assign md5_readaddr  = r_md5_readaddr;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_id        = r_out_id;
    assign out_last      = r_out_last;

endmodule
`default_nettype wire

// File: doc/md5_dispatcher.md
Name: md5_dispatcher

Overview:
- Hardware initiator for the md5group unit array; drives the same write, read, start, reset and done interface that software otherwise drives.
- Accepts 512-bit message blocks as a 32-bit word stream and loads each block into the lowest free unit, then starts that unit.
- Polls done flags, reads back each 128-bit digest and emits it, tagged with the job ID, on an output word stream.
- Sits between a DMA/stream source and md5group, replacing software control of the array.

Parameters:
- NUM_UNITS, 32, number of populated md5 units; legal range 1..32; upper md5_* vector bits are tied off.
- ID_W, 8, width of the job tag carried from input to output.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  32  message word; word 0 first
- in_id  in  ID_W  job tag; sampled on word 0 only
- out_valid  out  1  digest word valid
- out_ready  in  1  downstream accept
- out_data  out  32  digest word
- out_id  out  ID_W  tag of the job producing this digest
- out_last  out  1  final word of the digest
- md5_write  out  1  unit write strobe
- md5_writedata  out  32  unit write data
- md5_writeaddr  out  9  {unit[4:0], word[3:0]}
- md5_readaddr  out  7  {unit[4:0], word[1:0]}
- md5_readdata  in  32  digest word; valid 1 cycle after md5_readaddr
- md5_start  out  32  one-hot one-cycle start pulse
- md5_reset  out  32  per-unit reset
- md5_done  in  32  per-unit done level; held until that unit is reset

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0 except md5_reset = all ones. busy, counters and FSMs are cleared. Jobs in flight are dropped; no partial output is emitted. First cycle after reset release: md5_reset = 0.
- Free unit = !busy[u] for u < NUM_UNITS. The lowest-index free unit is selected by a priority encoder.
- Load FSM states: IDLE, LOAD, START.
  - IDLE -> LOAD when a free unit exists. The unit index is latched as lu and the word counter wc is set to 0.
  - LOAD: in_ready = 1. Each accepted word registers, on the next cycle, md5_write = 1, md5_writedata = in_data, md5_writeaddr = {lu, wc}; wc then increments.
  - On wc == 0 acceptance, in_id is stored into tag[lu]. After the word with wc == 15 is accepted -> START.
  - START: lasts exactly 1 cycle, following the final write cycle. md5_start[lu] = 1; busy[lu] is set; transition -> IDLE.
  - in_ready = 0 in IDLE, in START, and whenever no unit is free.
  - Back-to-back jobs: minimum of 18 cycles per block.
- Drain FSM states: SCAN, ADDR, DATA, HOLD, CLR. It runs concurrently with the load FSM.
  - SCAN: candidate = busy & md5_done & ~md5_start. The lowest such index is latched as du, then -> ADDR with rc = 0.
  - ADDR: md5_readaddr = {du, rc} -> DATA.
  - DATA: out_data <= md5_readdata; out_valid = 1; out_id = tag[du]; out_last = (rc == 3) -> HOLD.
  - HOLD: wait for out_ready; on handshake rc++ and -> ADDR, or -> CLR after rc == 3. out_* stay stable while out_valid && !out_ready.
  - CLR: md5_reset[du] = 1 for 1 cycle; busy[du] clears at the end of this cycle -> SCAN.
  - The unit becomes selectable by the load FSM the cycle after CLR. Load and drain therefore never target the same unit in the same cycle.
- md5_done of a non-busy unit is ignored.
- The done-to-first-output latency is 3 cycles.

Optional Feature:
- Macro: MD5_DISPATCH_CYCLES_EN.
- Defined:
  - A 32-bit per-unit counter is zeroed at START and incremented while the unit is busy and !done.
  - The digest is emitted as 5 words; word 4 is the counter value; out_last is asserted on word 4.
- Undefined: no counters; the digest is 4 words; out_last is asserted on word 3.

Decomposition:
- Package md5_dispatch_pkg holds:
  - WORDS_PER_BLOCK = 16 and DIGEST_WORDS = 4;
  - UNIT_AW = 5, BLK_WAW = 4 and DIG_WAW = 2;
  - the load and drain FSM state enums.
- Sub-module md5_dispatch_prienc: parameterised lowest-set-bit encoder, returning an index and a found flag. It is instantiated twice, once for free-unit selection and once for done scan.

Test Plan:
- Single job, id 0x5A, words 0x00000000..0x0000000F, stub unit 0 asserts done 40 cycles after start, readdata = 0xA0+word → writes to addresses 0x000..0x00F; one start[0] pulse; 4 output words 0xA0..0xA3 with out_id 0x5A; out_last on word 3; then a reset[0] pulse.
- 33 jobs issued back-to-back with done withheld → units 0..31 are allocated in order; in_ready stays 0 at job 33 until a done and drain occur, then job 33 loads into the freed unit.
- Units 3 and 7 assert done in the same cycle → unit 3's digest is emitted fully before unit 7's; the tags are preserved.
- out_ready held low for 10 cycles mid-digest → out_data, out_id and out_last remain stable; no readaddr advance; no word is lost.
- reset_n pulsed low while at word 9 of a load and mid-drain → the cycle after reset, md5_reset = 0xFFFFFFFF, all other outputs are 0, and no out_valid occurs; a new job then loads into unit 0.
- MD5_DISPATCH_CYCLES_EN defined, done after 64 cycles → a fifth word of 64 is emitted with out_last, on word 4 only.
